// File: rtl/branch_predictor_pkg.sv
// Shared encodings and defaults for the gshare branch predictor.
// Imported by the predictor top and its counter sub-module.
package branch_predictor_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] CTR_RESET = WNT;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-state logic for one 2-bit saturating direction counter.
// Purely combinational; the table register lives in the top.
module sat_counter_2b
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor: PC xor global history indexes 2-bit
// counters; trained and history-shifted only at branch resolution.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int INDEX_W = 4,
  parameter int STAT_W  = 16
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [DATA_W-1:0]  lookup_pc,
  output logic               prediction,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               resolve_valid,
  input  logic [INDEX_W-1:0] resolve_index,
  input  logic               resolve_taken,
  input  logic               resolve_pred,
  output logic               mispredict,
  output logic [STAT_W-1:0]  stat_branches,
  output logic [STAT_W-1:0]  stat_mispredicts
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam logic [STAT_W-1:0] STAT_ONE = 1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [1:0]         tbl_q [ENTRIES];
  logic [1:0]         tbl_d [ENTRIES];
  logic [INDEX_W-1:0] ghr_q, ghr_d;
  logic [STAT_W-1:0]  br_q, br_d;
  logic [STAT_W-1:0]  mis_q, mis_d;
  logic [1:0]         train_next;
  logic               unused_pc;

  // PC bits outside the index field never affect the lookup
  assign unused_pc = ^{lookup_pc[1:0], lookup_pc >> (INDEX_W + 2)};

  assign pred_index = lookup_pc[INDEX_W+1:2] ^ ghr_q;
  assign prediction = tbl_q[pred_index][1];

  assign mispredict = resolve_valid & (resolve_taken != resolve_pred);

  assign stat_branches    = br_q;
  assign stat_mispredicts = mis_q;

  sat_counter_2b u_train (
    .ctr_i   (tbl_q[resolve_index]),
    .taken_i (resolve_taken),
    .ctr_o   (train_next)
  );

  always_comb begin
    tbl_d = tbl_q;
    ghr_d = ghr_q;
    br_d  = br_q;
    mis_d = mis_q;
    if (resolve_valid) begin
      tbl_d[resolve_index] = train_next;
      ghr_d = {ghr_q[INDEX_W-2:0], resolve_taken};
      if (br_q != STAT_MAX) br_d = br_q + STAT_ONE;
      if (mispredict && (mis_q != STAT_MAX)) mis_d = mis_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= CTR_RESET;
      ghr_q <= '0;
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      ghr_q <= ghr_d;
      br_q  <= br_d;
      mis_q <= mis_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
// Built with STAT_W=4 so statistics saturation is reachable quickly.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        arst;
  logic [15:0] lookup_pc;
  logic        prediction;
  logic [3:0]  pred_index;
  logic        resolve_valid;
  logic [3:0]  resolve_index;
  logic        resolve_taken;
  logic        resolve_pred;
  logic        mispredict;
  logic [3:0]  stat_branches;
  logic [3:0]  stat_mispredicts;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .DATA_W  (16),
    .INDEX_W (4),
    .STAT_W  (4)
  ) dut (
    .clk              (clk),
    .arst             (arst),
    .lookup_pc        (lookup_pc),
    .prediction       (prediction),
    .pred_index       (pred_index),
    .resolve_valid    (resolve_valid),
    .resolve_index    (resolve_index),
    .resolve_taken    (resolve_taken),
    .resolve_pred     (resolve_pred),
    .mispredict       (mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [3:0] idx, input logic tk,
                         input logic pr);
    resolve_valid = 1'b1;
    resolve_index = idx;
    resolve_taken = tk;
    resolve_pred  = pr;
    tick();
    resolve_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [15:0] pc,
                      input logic [3:0] idx, input logic pr);
    lookup_pc = pc;
    #1;
    check({tag, "_idx"}, 32'(pred_index), 32'(idx));
    check({tag, "_pred"}, 32'(prediction), 32'(pr));
  endtask

  task automatic stats(input string tag, input logic [3:0] br,
                       input logic [3:0] mis);
    check({tag, "_br"}, 32'(stat_branches), 32'(br));
    check({tag, "_mis"}, 32'(stat_mispredicts), 32'(mis));
  endtask

  initial begin
    arst          = 1'b1;
    lookup_pc     = 16'h0000;
    resolve_valid = 1'b0;
    resolve_index = 4'd0;
    resolve_taken = 1'b0;
    resolve_pred  = 1'b0;
    tick();
    tick();
    arst = 1'b0;
    tick();

    // reset state
    look("rst", 16'h0010, 4'd4, 1'b0);
    stats("rst", 4'd0, 4'd0);

    // first taken resolve on index 4, predicted not-taken
    resolve_valid = 1'b1;
    resolve_index = 4'd4;
    resolve_taken = 1'b1;
    resolve_pred  = 1'b0;
    #1;
    check("mispredict_comb", 32'(mispredict), 32'd1);
    tick();
    resolve_valid = 1'b0;
    #1;
    check("mispredict_idle", 32'(mispredict), 32'd0);
    stats("first", 4'd1, 4'd1);
    look("ghr1_pc10", 16'h0010, 4'd5, 1'b0);
    look("ghr1_pc14", 16'h0014, 4'd4, 1'b1);

    // saturate index 7 upward; ghr 0001 -> 1111
    for (int i = 0; i < 4; i++) resolve(4'd7, 1'b1, 1'b1);
    stats("sat_up", 4'd5, 4'd1);
    look("idx7_st", 16'h0020, 4'd7, 1'b1);

    // 11 -> 10 still taken; ghr 1110
    resolve(4'd7, 1'b0, 1'b1);
    look("idx7_wt", 16'h0024, 4'd7, 1'b1);
    // 10 -> 01 not taken; ghr 1100
    resolve(4'd7, 1'b0, 1'b1);
    look("idx7_wnt", 16'h002C, 4'd7, 1'b0);
    stats("sat_dn", 4'd7, 4'd3);

    // same-cycle lookup and training on index 3: no bypass
    lookup_pc     = 16'h003C;
    resolve_valid = 1'b1;
    resolve_index = 4'd3;
    resolve_taken = 1'b1;
    resolve_pred  = 1'b0;
    #1;
    check("same_idx", 32'(pred_index), 32'd3);
    check("same_pred", 32'(prediction), 32'd0);
    tick();
    resolve_valid = 1'b0;
    // ghr now 1001
    look("next_idx3", 16'h0028, 4'd3, 1'b1);
    stats("same", 4'd8, 4'd4);

    // statistics saturate at 0xF
    for (int i = 0; i < 20; i++) resolve(4'd0, 1'b1, 1'b0);
    stats("stat_sat", 4'hF, 4'hF);
    resolve_valid = 1'b1;
    resolve_index = 4'd0;
    resolve_taken = 1'b1;
    resolve_pred  = 1'b1;
    #1;
    check("correct_comb", 32'(mispredict), 32'd0);
    tick();
    resolve_valid = 1'b0;
    stats("stat_hold", 4'hF, 4'hF);
    // ghr 1111, counter 0 is 11
    look("idx0_st", 16'h003C, 4'd0, 1'b1);

    // async reset between edges, with a resolve pending on that edge
    resolve_valid = 1'b1;
    resolve_index = 4'd0;
    resolve_taken = 1'b1;
    resolve_pred  = 1'b0;
    #2;
    arst = 1'b1;
    #1;
    look("arst_idx0", 16'h0000, 4'd0, 1'b0);
    look("arst_idx5", 16'h0014, 4'd5, 1'b0);
    stats("arst", 4'd0, 4'd0);
    tick();
    arst = 1'b0;
    resolve_valid = 1'b0;
    #1;
    stats("arst_edge", 4'd0, 4'd0);
    look("arst_edge", 16'h0000, 4'd0, 1'b0);

    // first training after reset release; ghr -> 0001
    resolve(4'd0, 1'b1, 1'b0);
    look("post_rst", 16'h0004, 4'd0, 1'b1);
    stats("post_rst", 4'd1, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
